mips_multicycle_core: RTL and testbench

Multicycle MIPS core that replaces the single-cycle top level. A controller FSM sequences the existing register file, ALU, ALU control, sign extend and multiplexers over several cycles. It uses one shared instruction/data memory port with a req/ack handshake, so it tolerates wait-state memories. The core adds loads, stores, branches, jumps, memory-mapped I/O and an illegal-instruction trap.

---
 rtl/mips_multicycle_core.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core
//   Multicycle MIPS core. A controller FSM steps each instruction through
//   FETCH / DECODE / EXEC / MEM / WB over one shared req/ack memory port,
//   so wait-state memories are tolerated. Unsupported encodings and
//   misaligned lw/sw enter an absorbing TRAP state.
//
//   Optional feature: define MIPS_CORE_MMIO_EN to decode MMIO_OUT_ADDR
//   (sw -> PortOut) and MMIO_IN_ADDR (lw -> zero-extended PortIn) inside
//   the core without a bus request. Undefined: PortOut is 0 and those
//   addresses go to the bus.
//
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-low
//   mem_req/we    transaction request / write enable
//   mem_addr      word-aligned byte address
//   mem_wdata     store data
//   mem_rdata     read data, valid in the ack cycle
//   mem_ack       transaction complete this cycle
//   PortIn        input port (MMIO build only)
//   PortOut       output port register
//   ALUResultOut  registered ALU result (updated at end of EXEC)
//   illegal       trap flag, held until reset
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC      = 32'h0040_0000,
  parameter int unsigned PORT_IN_WIDTH = 8,
  parameter logic [31:0] MMIO_OUT_ADDR = 32'hFFFF_0000,
  parameter logic [31:0] MMIO_IN_ADDR  = 32'hFFFF_0004
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ack,
  input  logic [PORT_IN_WIDTH-1:0] PortIn,
  output logic [31:0]              PortOut,
  output logic [31:0]              ALUResultOut,
  output logic                     illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_JR  = 6'h08,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24,
                         FN_OR  = 6'h25, FN_NOR = 6'h27, FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} coreState_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } aluSel_t;

  coreState_t state, nextState;
  aluSel_t    aluSel;

  logic [31:0] pc, ir, regA, regB, aluOut, mdr, branchTarget;
  logic [31:0] regFile [32];

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt, wbReg;
  logic [15:0] imm;
  logic [31:0] sextImm, zextImm, srcB, aluResult, mmioInData;
  logic        isRType, isLw, isSw, isBeq, isBne, isJ, isJal, isJr, legal;
  logic        misaligned, mmioHit, memDone, branchTaken;

  assign opcode  = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign shamt   = ir[10:6];
  assign funct   = ir[5:0];
  assign imm     = ir[15:0];
  assign sextImm = {{16{imm[15]}}, imm};
  assign zextImm = {16'h0000, imm};

  assign isRType = (opcode == OP_RTYPE);
  assign isLw    = (opcode == OP_LW);
  assign isSw    = (opcode == OP_SW);
  assign isBeq   = (opcode == OP_BEQ);
  assign isBne   = (opcode == OP_BNE);
  assign isJ     = (opcode == OP_J);
  assign isJal   = (opcode == OP_JAL);
  assign isJr    = isRType && (funct == FN_JR);
  assign legal   = isRType ? (funct inside {FN_SLL, FN_SRL, FN_JR, FN_ADD, FN_SUB,
                                            FN_AND, FN_OR, FN_NOR, FN_SLT})
                           : (opcode inside {OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                                             OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW});
  assign wbReg       = isRType ? rd : rt;
  assign branchTaken = (isBeq && (regA == regB)) || (isBne && (regA != regB));

  // ALU control: operation and second operand from opcode/funct
  always_comb begin
    aluSel = ALU_ADD;
    srcB   = regB;
    if (isRType) begin
      case (funct)
        FN_SUB:  aluSel = ALU_SUB;
        FN_AND:  aluSel = ALU_AND;
        FN_OR:   aluSel = ALU_OR;
        FN_NOR:  aluSel = ALU_NOR;
        FN_SLT:  aluSel = ALU_SLT;
        FN_SLL:  aluSel = ALU_SLL;
        FN_SRL:  aluSel = ALU_SRL;
        default: aluSel = ALU_ADD;
      endcase
    end else begin
      case (opcode)
        OP_ADDI, OP_LW, OP_SW: begin aluSel = ALU_ADD; srcB = sextImm; end
        OP_ANDI:               begin aluSel = ALU_AND; srcB = zextImm; end
        OP_ORI:                begin aluSel = ALU_OR;  srcB = zextImm; end
        OP_LUI:                aluSel = ALU_LUI;
        OP_BEQ, OP_BNE:        aluSel = ALU_SUB;
        default:               aluSel = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    aluResult = '0;
    case (aluSel)
      ALU_ADD: aluResult = regA + srcB;
      ALU_SUB: aluResult = regA - srcB;
      ALU_AND: aluResult = regA & srcB;
      ALU_OR:  aluResult = regA | srcB;
      ALU_NOR: aluResult = ~(regA | srcB);
      ALU_SLT: aluResult = {31'b0, ($signed(regA) < $signed(srcB))};
      ALU_SLL: aluResult = regB << shamt;
      ALU_SRL: aluResult = regB >> shamt;
      ALU_LUI: aluResult = {imm, 16'h0000};
      default: aluResult = '0;
    endcase
  end

  assign misaligned = (aluResult[1:0] != 2'b00);

`ifdef MIPS_CORE_MMIO_EN
  logic [31:0] portOutReg;

  assign mmioHit    = (isSw && (aluOut == MMIO_OUT_ADDR)) || (isLw && (aluOut == MMIO_IN_ADDR));
  assign mmioInData = 32'(PortIn);
  assign PortOut    = portOutReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      portOutReg <= '0;
    else if (state == MEM && isSw && mmioHit)
      portOutReg <= regB;
  end
`else
  logic unusedMmio;

  assign mmioHit    = 1'b0;
  assign mmioInData = '0;
  assign PortOut    = '0;
  assign unusedMmio = ^{PortIn, MMIO_OUT_ADDR, MMIO_IN_ADDR};
`endif

  // MMIO accesses finish in their single MEM cycle; bus accesses wait for ack
  assign memDone      = mmioHit || mem_ack;
  assign ALUResultOut = aluOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      FETCH:  if (mem_ack) nextState = DECODE;
      DECODE: begin
        if (!legal)             nextState = TRAP;
        else if (isJ || isJal)  nextState = FETCH;
        else                    nextState = EXEC;
      end
      EXEC: begin
        if (isLw || isSw)               nextState = misaligned ? TRAP : MEM;
        else if (isBeq || isBne || isJr) nextState = FETCH;
        else                            nextState = WB;
      end
      MEM:     if (memDone) nextState = isLw ? WB : FETCH;
      WB:      nextState = FETCH;
      TRAP:    nextState = TRAP;
      default: nextState = FETCH;
    endcase
  end

  // Bus outputs are gated by reset so an aborted request drops at once
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    illegal   = 1'b0;
    if (reset) begin
      case (state)
        FETCH: begin
          mem_req  = 1'b1;
          mem_addr = pc;
        end
        MEM: begin
          if (!mmioHit) begin
            mem_req   = 1'b1;
            mem_we    = isSw;
            mem_addr  = aluOut;
            mem_wdata = isSw ? regB : '0;
          end
        end
        TRAP:    illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      ir           <= '0;
      regA         <= '0;
      regB         <= '0;
      aluOut       <= '0;
      mdr          <= '0;
      branchTarget <= '0;
      for (int unsigned i = 0; i < 32; i++) regFile[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            pc <= pc + 32'd4;
          end
        end
        DECODE: begin
          regA         <= regFile[rs];
          regB         <= regFile[rt];
          branchTarget <= pc + {sextImm[29:0], 2'b00};
          if (isJ || isJal) pc <= {pc[31:28], ir[25:0], 2'b00};
          // pc already holds the return address (instruction + 4)
          if (isJal) regFile[31] <= pc;
        end
        EXEC: begin
          aluOut <= aluResult;
          if (branchTaken) pc <= branchTarget;
          if (isJr)        pc <= regA;
        end
        MEM: begin
          if (isLw && memDone) mdr <= mmioHit ? mmioInData : mem_rdata;
        end
        WB: begin
          if (wbReg != 5'd0) regFile[wbReg] <= isLw ? mdr : aluOut;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ack, illegal;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, PortOut, ALUResultOut;
  logic [7:0]  PortIn;

  always #5 clk = ~clk;

  mips_multicycle_core #(
    .RESET_PC(RST_PC),
    .PORT_IN_WIDTH(8),
    .MMIO_OUT_ADDR(32'hFFFF_0000),
    .MMIO_IN_ADDR(32'hFFFF_0004)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PortIn(PortIn), .PortOut(PortOut), .ALUResultOut(ALUResultOut), .illegal(illegal)
  );

  int compared, mismatched;

  // Memory model: imem covers 0x004xxxxx, dmem everything else
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          waitStates, cnt, runLen, cycle, unstable, runBad, reqCycles;
  logic [31:0] runAddr, runData;
  logic        runWe;
  logic [31:0] fAddr [512];
  int          fCyc  [512];
  int          fN;
  logic [31:0] dAddr [64];
  logic [31:0] dData [64];
  logic        dWe   [64];
  int          dN;

  always @(negedge clk) begin
    cycle++;
    if (mem_ack) mem_ack = 1'b0;
    if (!reset || !mem_req) begin
      cnt    = 0;
      runLen = 0;
    end else begin
      reqCycles++;
      if (runLen == 0) begin
        runAddr = mem_addr; runWe = mem_we; runData = mem_wdata;
      end else if (mem_addr !== runAddr || mem_we !== runWe || mem_wdata !== runData) begin
        unstable++;
      end
      runLen++;
      if (cnt == waitStates) begin
        mem_ack = 1'b1;
        if (runLen != waitStates + 1) runBad++;
        if (mem_addr[31:22] == 10'h001) begin
          mem_rdata = imem[mem_addr[9:2]];
          if (fN < 512) begin fAddr[fN] = mem_addr; fCyc[fN] = cycle; fN++; end
        end else begin
          mem_rdata = dmem[mem_addr[9:2]];
          if (mem_we) dmem[mem_addr[9:2]] = mem_wdata;
          if (dN < 64) begin
            dAddr[dN] = mem_addr; dWe[dN] = mem_we; dData[dN] = mem_wdata; dN++;
          end
        end
        cnt    = 0;
        runLen = 0;
      end else begin
        cnt++;
      end
    end
  end

  function automatic logic [31:0] rT(input int rs, input int rt, input int rd,
                                     input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] iT(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] jT(input int op, input logic [31:0] target);
    logic [31:0] w;
    w = target >> 2;
    return {6'(op), w[25:0]};
  endfunction

  function automatic int fetchAt(input logic [31:0] a, input int occ);
    int seen = 0;
    for (int i = 0; i < fN; i++) begin
      if (fAddr[i] == a) begin
        if (seen == occ) return fCyc[i];
        seen++;
      end
    end
    return -1000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input string tag, input int n, input logic [31:0] exp);
    check(tag, dut.regFile[n], exp);
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) begin imem[i] = '0; dmem[i] = '0; end
  endtask

  task automatic clearLogs();
    fN = 0; dN = 0; unstable = 0; runBad = 0; reqCycles = 0;
  endtask

  task automatic doReset(input int waits);
    reset = 1'b0;
    waitStates = waits;
    clearLogs();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitFetch(input string tag, input logic [31:0] a, input int budget);
    logic found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(posedge clk); #1;
      if (fN > 0 && fAddr[fN-1] == a) found = 1'b1;
    end
    check(tag, {31'b0, found}, 32'd1);
  endtask

  task automatic loadP1();
    clearMem();
    imem[8'h00] = iT(8'h08, 0, 8, 5);
    imem[8'h01] = iT(8'h08, 0, 9, -3);
    imem[8'h02] = rT(8, 9, 10, 0, 8'h20);
    imem[8'h03] = rT(8, 9, 11, 0, 8'h22);
    imem[8'h04] = rT(9, 8, 12, 0, 8'h2A);
    imem[8'h05] = iT(8'h0D, 0, 13, 16'hF0F0);
    imem[8'h06] = iT(8'h0C, 13, 14, 16'h0FF0);
    imem[8'h07] = iT(8'h0F, 0, 15, 16'h1234);
    imem[8'h08] = rT(0, 8, 16, 4, 8'h00);
    imem[8'h09] = rT(0, 15, 17, 16, 8'h02);
    imem[8'h0A] = rT(0, 0, 18, 0, 8'h27);
    imem[8'h0B] = iT(8'h2B, 0, 8, 0);
    imem[8'h0C] = iT(8'h23, 0, 19, 0);
    imem[8'h0D] = iT(8'h08, 0, 0, 9);
    imem[8'h0E] = iT(8'h08, 0, 20, 2);
    imem[8'h0F] = iT(8'h08, 20, 20, -1);
    imem[8'h10] = iT(8'h05, 20, 0, -2);
    imem[8'h11] = jT(8'h03, 32'h0040_0054);
    imem[8'h12] = jT(8'h02, 32'h0040_0048);
    imem[8'h15] = iT(8'h08, 0, 21, 7);
    imem[8'h16] = rT(31, 0, 0, 0, 8'h08);
  endtask

  initial begin
    compared = 0; mismatched = 0; cycle = 0; cnt = 0; runLen = 0;
    waitStates = 0; PortIn = 8'h3C; mem_ack = 1'b0; mem_rdata = '0;
    clearLogs();
    loadP1();

    // Reset state
    #1 reset = 1'b0;
    runCycles(2);
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst mem_we", {31'b0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst PortOut", PortOut, 32'd0);
    check("rst ALUResultOut", ALUResultOut, 32'd0);
    check("rst illegal", {31'b0, illegal}, 32'd0);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("first fetch req", {31'b0, mem_req}, 32'd1);
    check("first fetch addr", mem_addr, RST_PC);

    // ALU program, zero-wait memory
    waitFetch("wait add done", 32'h0040_000C, 40);
    check("add ALUResultOut", ALUResultOut, 32'd2);
    check("second fetch addr", fAddr[1], 32'h0040_0004);
    runCycles(150);
    checkReg("add $10", 10, 32'd2);
    checkReg("sub $11", 11, 32'd8);
    checkReg("slt $12", 12, 32'd1);
    checkReg("ori $13", 13, 32'h0000_F0F0);
    checkReg("andi $14", 14, 32'h0000_00F0);
    checkReg("lui $15", 15, 32'h1234_0000);
    checkReg("sll $16", 16, 32'h0000_0050);
    checkReg("srl $17", 17, 32'h0000_1234);
    checkReg("nor $18", 18, 32'hFFFF_FFFF);
    checkReg("lw $19", 19, 32'd5);
    checkReg("$0 stays 0", 0, 32'd0);
    checkReg("loop $20", 20, 32'd0);
    checkReg("callee $21", 21, 32'd7);
    checkReg("jal $31", 31, 32'h0040_0048);
    check("sw mem", dmem[0], 32'd5);
    check("data txns", 32'(dN), 32'd2);
    check("sw addr", dAddr[0], 32'd0);
    check("sw we", {31'b0, dWe[0]}, 32'd1);
    check("sw data", dData[0], 32'd5);
    check("lw we", {31'b0, dWe[1]}, 32'd0);
    check("cpi add", 32'(fetchAt(32'h0040_000C, 0) - fetchAt(32'h0040_0008, 0)), 32'd4);
    check("cpi sw", 32'(fetchAt(32'h0040_0030, 0) - fetchAt(32'h0040_002C, 0)), 32'd4);
    check("cpi lw", 32'(fetchAt(32'h0040_0034, 0) - fetchAt(32'h0040_0030, 0)), 32'd5);
    check("cpi bne taken", 32'(fetchAt(32'h0040_003C, 1) - fetchAt(32'h0040_0040, 0)), 32'd3);
    check("cpi bne not taken", 32'(fetchAt(32'h0040_0044, 0) - fetchAt(32'h0040_0040, 1)), 32'd3);
    check("cpi jal", 32'(fetchAt(32'h0040_0054, 0) - fetchAt(32'h0040_0044, 0)), 32'd2);
    check("cpi jr", 32'(fetchAt(32'h0040_0048, 0) - fetchAt(32'h0040_0058, 0)), 32'd3);

    // Same program with 3 wait states per access
    loadP1();
    doReset(3);
    runCycles(400);
    check("ws run length", 32'(runBad), 32'd0);
    check("ws stable", 32'(unstable), 32'd0);
    checkReg("ws lw $19", 19, 32'd5);
    checkReg("ws jal $31", 31, 32'h0040_0048);
    check("ws data txns", 32'(dN), 32'd2);
    check("ws lw addr", dAddr[1], 32'd0);
    check("ws cpi add", 32'(fetchAt(32'h0040_000C, 0) - fetchAt(32'h0040_0008, 0)), 32'd7);
    check("ws cpi lw", 32'(fetchAt(32'h0040_0034, 0) - fetchAt(32'h0040_0030, 0)), 32'd11);

    // MMIO program
    clearMem();
    dmem[1]     = 32'h1111_1111;
    imem[8'h00] = iT(8'h08, 0, 8, 16'h00A5);
    imem[8'h01] = iT(8'h0F, 0, 9, 16'hFFFF);
    imem[8'h02] = iT(8'h2B, 9, 8, 0);
    imem[8'h03] = iT(8'h23, 9, 10, 4);
    imem[8'h04] = jT(8'h02, 32'h0040_0010);
    doReset(0);
    runCycles(60);
    checkReg("mmio base $9", 9, 32'hFFFF_0000);
`ifdef MIPS_CORE_MMIO_EN
    check("mmio PortOut", PortOut, 32'h0000_00A5);
    checkReg("mmio lw PortIn", 10, 32'h0000_003C);
    check("mmio no bus txn", 32'(dN), 32'd0);
`else
    check("bus PortOut", PortOut, 32'd0);
    checkReg("bus lw", 10, 32'h1111_1111);
    check("bus txns", 32'(dN), 32'd2);
    check("bus sw addr", dAddr[0], 32'hFFFF_0000);
    check("bus sw data", dData[0], 32'h0000_00A5);
`endif

    // Illegal opcode trap
    clearMem();
    imem[8'h00] = iT(8'h08, 0, 8, 1);
    imem[8'h01] = 32'hFC00_0000;
    doReset(0);
    runCycles(30);
    check("trap illegal", {31'b0, illegal}, 32'd1);
    check("trap mem_req", {31'b0, mem_req}, 32'd0);
    check("trap fetches", 32'(fN), 32'd2);
    checkReg("trap $8", 8, 32'd1);
    reqCycles = 0;
    runCycles(20);
    check("trap req frozen", 32'(reqCycles), 32'd0);
    check("trap still illegal", {31'b0, illegal}, 32'd1);
    reset = 1'b0;
    #1;
    check("reset clears illegal", {31'b0, illegal}, 32'd0);
    check("reset drops req", {31'b0, mem_req}, 32'd0);

    // Misaligned load trap
    clearMem();
    imem[8'h00] = iT(8'h23, 0, 8, 2);
    doReset(0);
    runCycles(30);
    check("misaligned illegal", {31'b0, illegal}, 32'd1);
    check("misaligned no txn", 32'(dN), 32'd0);
    check("misaligned ALUResultOut", ALUResultOut, 32'd2);
    checkReg("misaligned $8", 8, 32'd0);

    // Unsupported R-type funct trap
    clearMem();
    imem[8'h00] = rT(0, 0, 8, 0, 8'h21);
    doReset(0);
    runCycles(20);
    check("bad funct illegal", {31'b0, illegal}, 32'd1);
    check("bad funct mem_req", {31'b0, mem_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
